rf_wb_arbiter: RTL

- Write side of the integer architectural register file: merges results from the ALU and the load/store unit (LSU) and drives the register file's single write-back port.
- Results are buffered in a small FIFO. Sources compete under round-robin arbitration, at most one accept per cycle.
- One write per cycle leaves the FIFO on registered outputs. The block sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter_if.sv | 41 ++++
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Handshake bundle between the ALU/LSU result producers, the write-back arbiter
// and the register file's write port p2.
interface rf_wb_arbiter_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;

   logic          lsu_valid;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          lsu_ready;

   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [CW-1:0] count;
   logic          busy;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output wb_we, wb_addr, wb_data, count, busy
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  wb_we, wb_addr, wb_data, count, busy
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin merge of ALU and LSU results into a FIFO that drains one register
// write per cycle. Define WB_X0_FILTER_EN to drop writes to x0. reset_i is active-low.
module rf_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input logic            clk_i,
   input logic            reset_i,
   rf_wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + DW;

   typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

   src_e          rrLast_q, rrLast_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic          wbWe_q;
   logic [AW-1:0] wbAddr_q;
   logic [DW-1:0] wbData_q;

   logic          space;
   logic          aluGrant;
   logic          lsuGrant;
   logic          push;
   logic          enq;
   logic          pop;
   logic [EW-1:0] pushEntry;
   logic [EW-1:0] headEntry;

   // Space ignores a same-cycle pop, so ready never depends on the drain path.
   always_comb begin
      space     = reset_i && (count_q < CW'(DEPTH));
      aluGrant  = space && bus.alu_valid && (!bus.lsu_valid || rrLast_q == SRC_LSU);
      lsuGrant  = space && bus.lsu_valid && (!bus.alu_valid || rrLast_q == SRC_ALU);
      push      = aluGrant || lsuGrant;
      pushEntry = aluGrant ? {bus.alu_rd, bus.alu_data} : {bus.lsu_rd, bus.lsu_data};
`ifdef WB_X0_FILTER_EN
      enq       = push && (pushEntry[EW-1:DW] != '0);
`else
      enq       = push;
`endif
      pop       = (count_q != '0);
      headEntry = mem_q[head_q];

      rrLast_d = rrLast_q;
      if (aluGrant) begin
         rrLast_d = SRC_ALU;
      end else if (lsuGrant) begin
         rrLast_d = SRC_LSU;
      end

      head_d  = pop ? head_q + 1'b1 : head_q;
      tail_d  = enq ? tail_q + 1'b1 : tail_q;
      count_d = count_q + CW'(enq) - CW'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[tail_q] <= pushEntry;
      end
   end

   // Address/data hold their last value when nothing drains.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rrLast_q <= SRC_LSU;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         wbWe_q   <= 1'b0;
         wbAddr_q <= '0;
         wbData_q <= '0;
      end else begin
         rrLast_q <= rrLast_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         wbWe_q   <= pop;
         if (pop) begin
            wbAddr_q <= headEntry[EW-1:DW];
            wbData_q <= headEntry[DW-1:0];
         end
      end
   end

   assign bus.alu_ready = aluGrant;
   assign bus.lsu_ready = lsuGrant;
   assign bus.wb_we     = wbWe_q;
   assign bus.wb_addr   = wbAddr_q;
   assign bus.wb_data   = wbData_q;
   assign bus.count     = count_q;
   assign bus.busy      = (count_q != '0) || wbWe_q;
endmodule
